// File: rtl/qsys_switch_debounce_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : qsys_switch_debounce_ctrl
// Purpose  : Avalon-MM slide-switch port with debounce, edge capture and IRQ
// Revision : 1.0
// =============================================================================
module qsys_switch_debounce_ctrl #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int              c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd1;
  localparam logic [1:0] c_ADDR_EDGE = 2'd2;
  localparam logic [1:0] c_ADDR_CTRL = 2'd3;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_edge_clr;
  logic             r_debounce_en;
  logic             w_wr;
  logic             w_toggle;
  logic [31:0]      w_rd_mux;

  assign w_wr     = chipselect && !write_n;
  assign w_toggle = w_wr && (address == c_ADDR_CTRL) && (writedata[0] != r_debounce_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [c_CNT_W-1:0] r_cnt;
      logic [c_CNT_W-1:0] w_cnt_nxt;
      logic               w_stab_bit;

      // A mode toggle restarts every count and leaves stable untouched that edge.
      always_comb begin
        w_cnt_nxt  = r_cnt;
        w_stab_bit = r_stable[i];
        if (w_toggle) begin
          w_cnt_nxt = '0;
        end else if (!r_debounce_en) begin
          w_cnt_nxt  = '0;
          w_stab_bit = r_s2[i];
        end else if (r_s2[i] == r_stable[i]) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt  = '0;
          w_stab_bit = r_s2[i];
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      assign w_stable_nxt[i] = w_stab_bit;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       w_edge_set = w_stable_nxt & ~r_stable;
      1:       w_edge_set = ~w_stable_nxt & r_stable;
      default: w_edge_set = w_stable_nxt ^ r_stable;
    endcase
  end

  assign w_edge_clr = (w_wr && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Set has priority over a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable      <= '0;
      r_edgecap     <= '0;
      r_irq_mask    <= '0;
      r_debounce_en <= 1'b1;
    end else begin
      r_stable  <= w_stable_nxt;
      r_edgecap <= (r_edgecap & ~w_edge_clr) | w_edge_set;
      if (w_wr && (address == c_ADDR_MASK)) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
      if (w_wr && (address == c_ADDR_CTRL)) begin
        r_debounce_en <= writedata[0];
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_stable;
      c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      c_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edgecap;
      c_ADDR_CTRL: w_rd_mux[0]         = r_debounce_en;
      default:     w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edgecap & r_irq_mask);

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic w_unused_wdata;
      assign w_unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_qsys_switch_debounce_ctrl.sv
`default_nettype none
// Bench for qsys_switch_debounce_ctrl: window-based debounce model compared
// every cycle, plus directed literal checks and an EDGE_TYPE=1 instance.
module tb_qsys_switch_debounce_ctrl;
  localparam int W = 10;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  logic          reset_n_b = 1'b0;
  logic [1:0]    address_b = 2'd2;
  logic          chipselect_b = 1'b0;
  logic          write_n_b = 1'b1;
  logic [31:0]   writedata_b = '0;
  logic [31:0]   readdata_b;
  logic [W-1:0]  in_port_b = '0;
  logic          irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qsys_switch_debounce_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  qsys_switch_debounce_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .address(address_b), .chipselect(chipselect_b),
    .write_n(write_n_b), .writedata(writedata_b), .readdata(readdata_b),
    .in_port(in_port_b), .irq(irq_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stable flips once the synchronised input has disagreed with it on
  // D consecutive edges with no restart (reset, bypass, toggle, flip) inside.
  logic [W-1:0] m_hist [0:63];
  int           m_e = 0;
  int           m_last_clr = -1;
  int           m_last_flip [W];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_ec = '0;
  logic         m_en = 1'b1;
  logic [31:0]  m_rd = '0;
  logic         m_irq = 1'b0;

  function automatic logic [W-1:0] seen(input int e);
    if (e < 2) return '0;
    return m_hist[(e - 2) % 64];
  endfunction

  task automatic model_reset();
    m_e = 0; m_last_clr = -1;
    for (int i = 0; i < W; i++) m_last_flip[i] = -1;
    m_stable = '0; m_mask = '0; m_ec = '0; m_en = 1'b1; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] nstab, setv, clrv, sv;
    logic [31:0]  rd;
    logic         wr, tog, ok;
    wr  = chipselect && !write_n;
    tog = wr && (address == 2'd3) && (writedata[0] != m_en);
    rd  = '0;
    case (address)
      2'd0: rd[W-1:0] = m_stable;
      2'd1: rd[W-1:0] = m_mask;
      2'd2: rd[W-1:0] = m_ec;
      default: rd[0] = m_en;
    endcase
    nstab = m_stable;
    if (tog || !m_en) m_last_clr = m_e;
    if (!tog && !m_en) begin
      nstab = seen(m_e);
    end else if (!tog) begin
      for (int i = 0; i < W; i++) begin
        ok = (m_e - D + 1 > m_last_clr) && (m_e - D + 1 > m_last_flip[i]);
        for (int k = 0; k < D; k++) begin
          sv = seen(m_e - k);
          if (sv[i] == m_stable[i]) ok = 1'b0;
        end
        if (ok) begin
          nstab[i] = ~m_stable[i];
          m_last_flip[i] = m_e;
        end
      end
    end
    setv = nstab ^ m_stable;
    clrv = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
    m_ec = (m_ec & ~clrv) | setv;
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
    if (wr && address == 2'd3) m_en = writedata[0];
    m_stable = nstab;
    m_rd = rd;
    m_irq = |(m_ec & m_mask);
    m_hist[m_e % 64] = in_port;
    m_e++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("cyc_readdata", readdata, m_rd);
    chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    address = a;
    tick();
    chk(name, readdata, exp);
  endtask

  initial begin
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    #22;
    reset_n = 1'b1;
    reset_n_b = 1'b1;
    bus_rd(2'd3, "rst_ctrl", 32'h1);
    bus_rd(2'd1, "rst_mask", 32'h0);
    bus_rd(2'd2, "rst_ec", 32'h0);
    bus_rd(2'd0, "rst_data", 32'h0);

    // Clean rise on bit 0
    in_port = 10'h001;
    tick(6);
    chk("rise_early", readdata, 32'h0);
    tick(1);
    chk("rise_data", readdata, 32'h1);
    bus_rd(2'd2, "rise_ec", 32'h1);
    chk("rise_irq", {31'b0, irq}, 32'h0);

    // Glitch then full-length pulse on bit 3
    in_port = 10'h009;
    tick(3);
    in_port = 10'h001;
    tick(8);
    bus_rd(2'd0, "glitch_data", 32'h001);
    bus_rd(2'd2, "glitch_ec", 32'h001);
    address = 2'd0;
    in_port = 10'h009;
    tick(4);
    in_port = 10'h001;
    tick(3);
    chk("pulse_high", readdata, 32'h009);
    tick(9);
    bus_rd(2'd0, "pulse_low", 32'h001);
    bus_rd(2'd2, "pulse_ec", 32'h009);

    // Interrupt flow on bit 9
    bus_wr(2'd1, 32'h200);
    in_port = 10'h201;
    for (int k = 0; k < 20 && !irq; k++) tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_rd(2'd2, "irq_ec", 32'h209);
    bus_wr(2'd2, 32'h200);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    in_port = 10'h001;
    for (int k = 0; k < 20 && !irq; k++) tick();
    chk("irq_fall_set", {31'b0, irq}, 32'h1);
    bus_wr(2'd2, 32'h100);
    chk("irq_keep", {31'b0, irq}, 32'h1);
    bus_rd(2'd2, "irq_ec_keep", 32'h209);

    // Clear colliding with a new fall on bit 0
    bus_wr(2'd2, 32'h3FF);
    bus_rd(2'd2, "coll_pre", 32'h0);
    in_port = 10'h000;
    tick(5);
    bus_wr(2'd2, 32'h001);
    bus_rd(2'd2, "coll_ec", 32'h001);
    bus_rd(2'd0, "coll_data", 32'h000);

    // Bypass
    bus_wr(2'd3, 32'h0);
    address = 2'd0;
    in_port = 10'h3FF;
    tick(3);
    chk("byp_early", readdata, 32'h0);
    tick(1);
    chk("byp_data", readdata, 32'h3FF);
    bus_rd(2'd3, "byp_ctrl", 32'h0);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, "byp_ctrl_on", 32'h1);
    address = 2'd0;
    in_port = 10'h000;
    tick(6);
    chk("deb_early", readdata, 32'h3FF);
    tick(1);
    chk("deb_data", readdata, 32'h0);

    // Reset mid-count with the switches held high
    bus_wr(2'd1, 32'h3FF);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    address = 2'd1;
    in_port = 10'h3FF;
    tick(3);
    chk("pre_rst_mask", readdata, 32'h3FF);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_readdata", readdata, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    bus_rd(2'd1, "rst_mid_mask", 32'h0);
    tick(8);
    bus_rd(2'd2, "rerise_ec", 32'h3FF);
    bus_rd(2'd0, "rerise_data", 32'h3FF);
    chk("rerise_irq", {31'b0, irq}, 32'h0);

    // EDGE_TYPE=1 instance: falling edges only
    in_port_b = 10'h004;
    tick(10);
    chk("e1_rise_ec", readdata_b, 32'h0);
    in_port_b = 10'h000;
    tick(10);
    chk("e1_fall_ec", readdata_b, 32'h004);
    chk("e1_irq", {31'b0, irq_b}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
